// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 exception block: CP0 register
// numbers, field bit positions, exception codes and small packing/arithmetic
// helpers used by the exception controller.
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // SR field positions
    localparam int unsigned SR_IE_BIT  = 0;
    localparam int unsigned SR_EXL_BIT = 1;
    localparam int unsigned SR_IM_LSB  = 10;
    localparam int unsigned SR_IM_MSB  = 15;

    // Cause field positions
    localparam int unsigned CAUSE_BD_BIT  = 31;
    localparam int unsigned CAUSE_IP_LSB  = 10;
    localparam int unsigned CAUSE_EXC_LSB = 2;

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    // Value carried by the exception pipeline registers when nothing is pending
    localparam logic [4:0] NO_EXC   = 5'h1f;

    // SR read image: IM[15:10], EXL[1], IE[0], all other bits zero
    function automatic logic [31:0] sr_pack(input logic [5:0] im,
                                            input logic       exl,
                                            input logic       ie);
        sr_pack = {16'h0000, im, 8'h00, exl, ie};
    endfunction

    // Cause read image: BD[31], IP[15:10], ExcCode[6:2], all other bits zero
    function automatic logic [31:0] cause_pack(input logic       bd,
                                               input logic [5:0] ip,
                                               input logic [4:0] code);
        cause_pack = {bd, 15'h0000, ip, 3'b000, code, 2'b00};
    endfunction

    // Restart address: word-aligned PC, backed up one word for a delay slot
    // so that the branch itself is re-executed. Wraps modulo 2^32.
    function automatic logic [31:0] epc_calc(input logic [31:0] pc,
                                             input logic        bd);
        logic [31:0] aligned;
        aligned  = {pc[31:2], 2'b00};
        epc_calc = bd ? (aligned - 32'd4) : aligned;
    endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Two-flop synchronizer for the external interrupt lines.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset
//   d     - asynchronous interrupt lines
//   q     - synchronized lines (two clock edges of latency)
module cp0_int_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] d,
    output logic [5:0] q
);

    logic [5:0] meta_r;
    logic [5:0] sync_r;

    // Two back-to-back flops; the first may go metastable, the second resolves it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_r <= 6'b000000;
            sync_r <= 6'b000000;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception responder at the M stage. Commits exceptions and
// interrupts into SR/Cause/EPC, raises the pipeline flush and redirects fetch
// to the handler, or back to EPC on eret. EXL is the only mode bit: 0 means
// normal execution, 1 means inside the handler with everything masked.
// Ports:
//   clk, reset       - clock, asynchronous active-low reset
//   pc_m, exc_code_m - M-stage PC (0 = bubble) and ExcCode (NO_EXC = none)
//   bd_m             - M-stage instruction is in a branch delay slot
//   hw_int           - asynchronous external interrupt lines
//   cp0_we/addr/wdata- mtc0 commit; cp0_addr also selects the mfc0 read
//   eret_m           - eret in M stage
//   cp0_rdata        - mfc0 read data (combinational, pre-edge values)
//   epc_out          - current EPC
//   exc_flush        - flush pipeline and exception registers this cycle
//   redirect_pc/valid- fetch redirect target and strobe
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL   = 32'h2017_1227
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_m,
    input  logic [4:0]  exc_code_m,
    input  logic        bd_m,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic        eret_m,
    output logic [31:0] cp0_rdata,
    output logic [31:0] epc_out,
    output logic        exc_flush,
    output logic [31:0] redirect_pc,
    output logic        redirect_valid
);

    logic [5:0]  ip_s;
    logic [5:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    logic        bd_r;
    logic [4:0]  exc_code_r;
    logic [31:0] epc_r;

    logic        int_req_s;
    logic        exc_req_s;
    logic        take_s;
    logic        eret_act_s;
    logic        mtc0_act_s;

    // Cause.IP is simply the synchronized interrupt lines, refreshed every cycle
    cp0_int_sync u_int_sync (
        .clk   (clk),
        .reset (reset),
        .d     (hw_int),
        .q     (ip_s)
    );

    // Request decode: interrupts need an unmasked line, IE set, and a real
    // instruction in M to attach EPC to; EXL masks both sources.
    always_comb begin
        int_req_s  = 1'b0;
        exc_req_s  = 1'b0;
        take_s     = 1'b0;
        eret_act_s = 1'b0;
        mtc0_act_s = 1'b0;
        if (!exl_r) begin
            int_req_s = (|(ip_s & im_r)) & ie_r & (pc_m != 32'h0000_0000);
            exc_req_s = (exc_code_m != NO_EXC);
        end else begin
            int_req_s = 1'b0;
            exc_req_s = 1'b0;
        end
        take_s     = int_req_s | exc_req_s;
        // A taken exception overrides a concurrent eret, and either one drops mtc0
        eret_act_s = eret_m & ~take_s;
        mtc0_act_s = cp0_we & ~take_s & ~eret_m;
    end

    // CP0 state update: exception entry, eret exit, or mtc0 write, in that priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_r       <= 6'b000000;
            exl_r      <= 1'b0;
            ie_r       <= 1'b0;
            bd_r       <= 1'b0;
            exc_code_r <= 5'd0;
            epc_r      <= 32'h0000_0000;
        end else if (take_s) begin
            exl_r      <= 1'b1;
            bd_r       <= bd_m;
            exc_code_r <= int_req_s ? EXC_INT : exc_code_m;
            epc_r      <= epc_calc(pc_m, bd_m);
        end else if (eret_act_s) begin
            exl_r      <= 1'b0;
        end else if (mtc0_act_s) begin
            case (cp0_addr)
                CP0_SR: begin
                    im_r  <= cp0_wdata[SR_IM_MSB:SR_IM_LSB];
                    exl_r <= cp0_wdata[SR_EXL_BIT];
                    ie_r  <= cp0_wdata[SR_IE_BIT];
                end
                CP0_EPC: begin
                    epc_r <= cp0_wdata;
                end
                // Cause and PRId are not software-writable
                default: begin
                end
            endcase
        end else begin
            exl_r <= exl_r;
        end
    end

    // Mealy redirect/flush; reset forces them off immediately, even mid-handler
    always_comb begin
        exc_flush      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        if (!reset) begin
            exc_flush      = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = 32'h0000_0000;
        end else if (take_s) begin
            exc_flush      = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = HANDLER_PC;
        end else if (eret_m) begin
            // Pre-edge EPC: a same-cycle mtc0 to EPC is dropped anyway
            exc_flush      = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = epc_r;
        end else begin
            exc_flush      = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = 32'h0000_0000;
        end
    end

    // mfc0 read mux over current register contents, no write bypass
    always_comb begin
        cp0_rdata = 32'h0000_0000;
        if (!reset) begin
            cp0_rdata = 32'h0000_0000;
        end else begin
            case (cp0_addr)
                CP0_SR:    cp0_rdata = sr_pack(im_r, exl_r, ie_r);
                CP0_CAUSE: cp0_rdata = cause_pack(bd_r, ip_s, exc_code_r);
                CP0_EPC:   cp0_rdata = epc_r;
                CP0_PRID:  cp0_rdata = PRID_VAL;
                default:   cp0_rdata = 32'h0000_0000;
            endcase
        end
    end

    assign epc_out = epc_r;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl. The stimulus side computes the expected
// outputs of each cycle from a register-level model of CP0 and queues them;
// the monitor pops one entry per cycle at the falling edge and compares.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_m;
    logic [4:0]  exc_code_m;
    logic        bd_m;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        eret_m;
    logic [31:0] cp0_rdata;
    logic [31:0] epc_out;
    logic        exc_flush;
    logic [31:0] redirect_pc;
    logic        redirect_valid;

    localparam logic [4:0] NOX = 5'h1f;
    localparam logic [4:0] CODES [4] = '{5'd4, 5'd5, 5'd10, 5'd12};

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rv;
        logic        fl;
        logic [31:0] rpc;
        logic [31:0] rd;
        logic [31:0] epc;
    } exp_t;

    exp_t exp_q [$];

    // Reference model state
    logic [5:0]  m_im;
    logic        m_exl;
    logic        m_ie;
    logic        m_bd;
    logic [4:0]  m_code;
    logic [31:0] m_epc;
    logic [5:0]  hw_prev1;
    logic [5:0]  hw_prev2;

    cp0_exc_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .pc_m           (pc_m),
        .exc_code_m     (exc_code_m),
        .bd_m           (bd_m),
        .hw_int         (hw_int),
        .cp0_we         (cp0_we),
        .cp0_addr       (cp0_addr),
        .cp0_wdata      (cp0_wdata),
        .eret_m         (eret_m),
        .cp0_rdata      (cp0_rdata),
        .epc_out        (epc_out),
        .exc_flush      (exc_flush),
        .redirect_pc    (redirect_pc),
        .redirect_valid (redirect_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_im = 6'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0;
        m_code = 5'd0; m_epc = 32'd0; hw_prev1 = 6'd0; hw_prev2 = 6'd0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic [5:0] ip);
        case (a)
            5'd12:   return 32'(m_im) * 32'd1024 + 32'(m_exl) * 32'd2 + 32'(m_ie);
            5'd13:   return 32'(m_bd) * 32'h8000_0000 + 32'(ip) * 32'd1024 + 32'(m_code) * 32'd4;
            5'd14:   return m_epc;
            5'd15:   return 32'h2017_1227;
            default: return 32'd0;
        endcase
    endfunction

    // One cycle: drive, queue the expected response, then advance the model at the edge
    task automatic step(input logic [31:0] pc, input logic [4:0] code, input logic bd,
                        input logic [5:0] hw, input logic we, input logic [4:0] addr,
                        input logic [31:0] wd, input logic er);
        exp_t e;
        logic [5:0] ip;
        logic ir, xr, tk;
        pc_m = pc; exc_code_m = code; bd_m = bd; hw_int = hw;
        cp0_we = we; cp0_addr = addr; cp0_wdata = wd; eret_m = er;
        ip = hw_prev2;
        ir = ((ip & m_im) != 6'd0) && m_ie && !m_exl && (pc != 32'd0);
        xr = (code != NOX) && !m_exl;
        tk = ir || xr;
        e.rv  = tk || er;
        e.fl  = tk || er;
        e.rpc = tk ? 32'h0000_4180 : (er ? m_epc : 32'd0);
        e.rd  = model_read(addr, ip);
        e.epc = m_epc;
        exp_q.push_back(e);
        @(posedge clk);
        hw_prev2 = hw_prev1;
        hw_prev1 = hw;
        if (tk) begin
            m_exl  = 1'b1;
            m_bd   = bd;
            m_code = ir ? 5'd0 : code;
            m_epc  = (pc / 32'd4) * 32'd4 - (bd ? 32'd4 : 32'd0);
        end else if (er) begin
            m_exl = 1'b0;
        end else if (we && addr == 5'd12) begin
            m_im = wd[15:10]; m_exl = wd[1]; m_ie = wd[0];
        end else if (we && addr == 5'd14) begin
            m_epc = wd;
        end
        #1;
    endtask

    // Monitor: one queued expectation per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
            chk("exc_flush", {31'd0, exc_flush}, {31'd0, e.fl});
            chk("redirect_pc", redirect_pc, e.rpc);
            chk("cp0_rdata", cp0_rdata, e.rd);
            chk("epc_out", epc_out, e.epc);
        end
    end

    task automatic idle_inputs();
        pc_m = 32'd0; exc_code_m = NOX; bd_m = 1'b0; hw_int = 6'd0;
        cp0_we = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'd0; eret_m = 1'b0;
    endtask

    // Reset pulse asserted mid-cycle while an eret is being presented
    task automatic mid_reset();
        eret_m = 1'b1; cp0_addr = 5'd12; pc_m = 32'h0000_3050; exc_code_m = NOX;
        #1 reset = 1'b0;
        #1;
        chk("rst_exc_flush", {31'd0, exc_flush}, 32'd0);
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_epc_out", epc_out, 32'd0);
        chk("rst_sr", cp0_rdata, 32'd0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pc;
        logic [4:0]  code;
        logic [5:0]  hw;
        logic [4:0]  addr;
        idle_inputs();
        model_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset state of every readable register
        step(32'd0, NOX, 1'b0, 6'd0, 1'b0, 5'd12, 32'd0, 1'b0);
        step(32'd0, NOX, 1'b0, 6'd0, 1'b0, 5'd13, 32'd0, 1'b0);
        step(32'd0, NOX, 1'b0, 6'd0, 1'b0, 5'd14, 32'd0, 1'b0);
        step(32'd0, NOX, 1'b0, 6'd0, 1'b0, 5'd15, 32'd0, 1'b0);

        // Overflow at 0x3010, then eret back to it
        step(32'h3010, 5'd12, 1'b0, 6'd0, 1'b0, 5'd14, 32'd0, 1'b0);
        step(32'd0, NOX, 1'b0, 6'd0, 1'b0, 5'd13, 32'd0, 1'b0);
        step(32'd0, NOX, 1'b0, 6'd0, 1'b0, 5'd12, 32'd0, 1'b0);
        step(32'h3014, 5'd10, 1'b0, 6'd0, 1'b0, 5'd13, 32'd0, 1'b0);
        step(32'd0, NOX, 1'b0, 6'd0, 1'b0, 5'd12, 32'd0, 1'b1);
        step(32'd0, NOX, 1'b0, 6'd0, 1'b0, 5'd12, 32'd0, 1'b0);

        // Reserved instruction in a delay slot
        step(32'h3020, 5'd10, 1'b1, 6'd0, 1'b0, 5'd14, 32'd0, 1'b0);
        step(32'd0, NOX, 1'b0, 6'd0, 1'b0, 5'd13, 32'd0, 1'b0);
        // eret with a concurrent mtc0 EPC: write dropped, old EPC used
        step(32'd0, NOX, 1'b0, 6'd0, 1'b1, 5'd14, 32'hBEEF, 1'b1);
        step(32'd0, NOX, 1'b0, 6'd0, 1'b0, 5'd14, 32'd0, 1'b0);

        // Exception beats a same-cycle mtc0 EPC
        step(32'h3030, 5'd4, 1'b0, 6'd0, 1'b1, 5'd14, 32'hDEAD, 1'b0);
        step(32'd0, NOX, 1'b0, 6'd0, 1'b0, 5'd14, 32'd0, 1'b0);
        // Take beats a same-cycle eret is impossible here (EXL=1), so eret exits
        step(32'd0, NOX, 1'b0, 6'd0, 1'b0, 5'd12, 32'd0, 1'b1);
        // Exception and eret together with EXL=0: take wins
        step(32'h3034, 5'd5, 1'b0, 6'd0, 1'b0, 5'd13, 32'd0, 1'b1);
        step(32'd0, NOX, 1'b0, 6'd0, 1'b0, 5'd12, 32'd0, 1'b1);

        // Interrupt line 0 enabled; bubbles do not take; first real PC does
        step(32'd0, NOX, 1'b0, 6'd1, 1'b1, 5'd12, 32'h0000_0401, 1'b0);
        repeat (3) step(32'd0, NOX, 1'b0, 6'd1, 1'b0, 5'd13, 32'd0, 1'b0);
        step(32'h3040, NOX, 1'b0, 6'd1, 1'b0, 5'd13, 32'd0, 1'b0);
        step(32'd0, NOX, 1'b0, 6'd1, 1'b0, 5'd13, 32'd0, 1'b0);
        step(32'd0, NOX, 1'b0, 6'd0, 1'b0, 5'd12, 32'd0, 1'b1);
        step(32'd0, NOX, 1'b0, 6'd0, 1'b1, 5'd12, 32'd0, 1'b0);

        // Reset while inside the handler
        step(32'h3050, 5'd12, 1'b0, 6'd0, 1'b0, 5'd12, 32'd0, 1'b0);
        mid_reset();
        step(32'd0, NOX, 1'b0, 6'd0, 1'b0, 5'd12, 32'd0, 1'b0);
        step(32'd0, NOX, 1'b0, 6'd0, 1'b0, 5'd14, 32'd0, 1'b0);

        // Randomized traffic
        hw = 6'd0;
        for (int i = 0; i < 600; i++) begin
            pc   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            code = ($urandom_range(0, 4) == 0) ? CODES[$urandom_range(0, 3)] : NOX;
            if ($urandom_range(0, 9) == 0) hw = 6'($urandom);
            addr = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            step(pc, code, (pc != 32'd0) && ($urandom_range(0, 3) == 0), hw,
                 ($urandom_range(0, 3) == 0), addr, $urandom,
                 ($urandom_range(0, 5) == 0));
        end

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
